// File: rtl/actuator_scheduler.sv
// actuator_scheduler: grants one of six actuators at a time. The alarm buzzer
// (req[2]) always wins; the other requesters share round-robin. Each grant is
// held for a dwell period and followed by an all-off guard gap.
// Optional feature: define HVAC_INTERLOCK_EN to add the heater/cooler
// interlock (simultaneous-request conflict and changeover lockout).
module actuator_scheduler #(
  parameter int DWELL_CYCLES   = 8,
  parameter int GUARD_CYCLES   = 2,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] req,
  output logic [5:0] grant,
  output logic [2:0] code,
  output logic       busy,
  output logic       preempted,
  output logic       conflict
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t     state_reg, state_next;
  logic [5:0] grant_reg, grant_next;
  logic [2:0] code_reg, code_next;
  logic       busy_reg, busy_next;
  logic       preempt_reg, preempt_next;
  logic [7:0] dwell_reg, dwell_next;
  logic [3:0] guard_reg, guard_next;
  logic [2:0] rr_reg, rr_next;

  logic [5:0] eligible;
  logic       pick_valid;
  logic [2:0] pick_idx;
  logic [3:0] cand;
  logic       try_start;

`ifdef HVAC_INTERLOCK_EN
  logic [7:0] lock_reg, lock_next;
  logic       lock_cooler_reg, lock_cooler_next;

  assign conflict = req[4] & req[5];

  // Mask heater/cooler when both ask at once, or when the other side ran recently.
  always_comb begin
    eligible = req;
    if (req[4] && req[5]) begin
      eligible[5:4] = 2'b00;
    end else if (lock_reg != 8'd0) begin
      if (lock_cooler_reg) eligible[5] = 1'b0;
      else                 eligible[4] = 1'b0;
    end
  end

  // Lockout counts down continuously; it reloads when a heater/cooler grant ends.
  always_comb begin
    lock_next        = (lock_reg == 8'd0) ? 8'd0 : lock_reg - 8'd1;
    lock_cooler_next = lock_cooler_reg;
    if ((grant_reg[5:4] != 2'b00) && (grant_next[5:4] == 2'b00)) begin
      lock_next        = 8'(LOCKOUT_CYCLES);
      lock_cooler_next = grant_reg[4];
    end
  end

  // Lockout state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_reg        <= 8'd0;
      lock_cooler_reg <= 1'b0;
    end else begin
      lock_reg        <= lock_next;
      lock_cooler_reg <= lock_cooler_next;
    end
  end
`else
  assign eligible = req;
  assign conflict = 1'b0;
`endif

  // Winner selection: alarm first, else first eligible bit after the last grant.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    cand       = 4'd0;
    if (eligible[2]) begin
      pick_valid = 1'b1;
      pick_idx   = 3'd2;
    end else begin
      for (int k = 1; k <= 6; k++) begin
        cand = {1'b0, rr_reg} + 4'(k);
        if (cand >= 4'd6) cand = cand - 4'd6;
        if (!pick_valid && eligible[cand[2:0]]) begin
          pick_valid = 1'b1;
          pick_idx   = cand[2:0];
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    dwell_next   = dwell_reg;
    guard_next   = guard_reg;
    rr_next      = rr_reg;
    preempt_next = 1'b0;
    try_start    = 1'b0;
    code_next    = 3'd0;

    case (state_reg)
      IDLE: try_start = 1'b1;
      GRANT: begin
        if ((grant_reg & req) == 6'd0 || (!grant_reg[2] && req[2])) begin
          // Requester let go, or alarm cut in on a non-alarm grant.
          state_next   = GUARD;
          grant_next   = 6'd0;
          guard_next   = 4'(GUARD_CYCLES - 1);
          preempt_next = !grant_reg[2] && req[2] && ((grant_reg & req) != 6'd0);
        end else if (grant_reg[2]) begin
          dwell_next = 8'(DWELL_CYCLES - 1);
        end else if (dwell_reg == 8'd0) begin
          state_next = GUARD;
          grant_next = 6'd0;
          guard_next = 4'(GUARD_CYCLES - 1);
        end else begin
          dwell_next = dwell_reg - 8'd1;
        end
      end
      GUARD: begin
        grant_next = 6'd0;
        if (guard_reg == 4'd0) try_start = 1'b1;
        else                   guard_next = guard_reg - 4'd1;
      end
      default: begin
        state_next = IDLE;
        grant_next = 6'd0;
      end
    endcase

    if (try_start) begin
      if (pick_valid) begin
        state_next = GRANT;
        grant_next = 6'b000001 << pick_idx;
        dwell_next = 8'(DWELL_CYCLES - 1);
        if (pick_idx != 3'd2) rr_next = pick_idx;
      end else begin
        state_next = IDLE;
        grant_next = 6'd0;
      end
    end

    for (int i = 0; i < 6; i++) begin
      if (grant_next[i]) code_next = 3'(i + 1);
    end
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 6'd0;
      code_reg    <= 3'd0;
      busy_reg    <= 1'b0;
      preempt_reg <= 1'b0;
      dwell_reg   <= 8'd0;
      guard_reg   <= 4'd0;
      rr_reg      <= 3'd5;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      code_reg    <= code_next;
      busy_reg    <= busy_next;
      preempt_reg <= preempt_next;
      dwell_reg   <= dwell_next;
      guard_reg   <= guard_next;
      rr_reg      <= rr_next;
    end
  end

  assign grant     = grant_reg;
  assign code      = code_reg;
  assign busy      = busy_reg;
  assign preempted = preempt_reg;

endmodule

// File: tb/tb_actuator_scheduler.sv
// Directed testbench for actuator_scheduler (DWELL=8, GUARD=2, LOCKOUT=16).
// Expected per-cycle outputs are queued as each step is driven and compared
// at the falling edge following each rising edge.
module tb_actuator_scheduler;

  logic       clk;
  logic       reset;
  logic [5:0] req;
  logic [5:0] grant;
  logic [2:0] code;
  logic       busy;
  logic       preempted;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] g;
    logic       b;
    logic       p;
    logic       c;
  } exp_t;

  exp_t sb[$];

  actuator_scheduler #(
    .DWELL_CYCLES(8),
    .GUARD_CYCLES(2),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .code(code),
    .busy(busy),
    .preempted(preempted),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] enc(input logic [5:0] g);
    logic [2:0] r;
    r = 3'd0;
    case (g)
      6'b000001: r = 3'd1;
      6'b000010: r = 3'd2;
      6'b000100: r = 3'd3;
      6'b001000: r = 3'd4;
      6'b010000: r = 3'd5;
      6'b100000: r = 3'd6;
      default:   r = 3'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] g, input logic b, input logic p, input logic c, input int n);
    exp_t e;
    e.g = g; e.b = b; e.p = p; e.c = c;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Advance one clock per queued entry and compare at the falling edge.
  task automatic run_all(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".grant"}, {2'b00, grant}, {2'b00, e.g});
      chk({tag, ".code"}, {5'd0, code}, {5'd0, enc(e.g)});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.b});
      chk({tag, ".preempted"}, {7'd0, preempted}, {7'd0, e.p});
      chk({tag, ".conflict"}, {7'd0, conflict}, {7'd0, e.c});
      $display("cycle %s grant=%b code=%0d busy=%b pre=%b conf=%b", tag, grant, code, busy, preempted, conflict);
    end
  endtask

  // Hold reset, check the reset state, then release at a falling edge with new req.
  task automatic do_reset(input logic [5:0] r);
    reset = 1'b0;
    req   = 6'd0;
    repeat (2) @(negedge clk);
    chk("rst.grant", {2'b00, grant}, 8'd0);
    chk("rst.code", {5'd0, code}, 8'd0);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.preempted", {7'd0, preempted}, 8'd0);
    req   = r;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = 6'd0;

    // Single requester: 8 on, 2 off, regranted.
    do_reset(6'b000001);
    push(6'b000001, 1, 0, 0, 8);
    push(6'b000000, 1, 0, 0, 2);
    push(6'b000001, 1, 0, 0, 3);
    run_all("single");

    // Round-robin order bit0, bit1, bit3, bit0.
    do_reset(6'b001011);
    push(6'b000001, 1, 0, 0, 8); push(6'b000000, 1, 0, 0, 2);
    push(6'b000010, 1, 0, 0, 8); push(6'b000000, 1, 0, 0, 2);
    push(6'b001000, 1, 0, 0, 8); push(6'b000000, 1, 0, 0, 2);
    push(6'b000001, 1, 0, 0, 8);
    run_all("rr");

    // Alarm preemption, alarm dwell renewal, alarm release.
    do_reset(6'b001000);
    push(6'b001000, 1, 0, 0, 3);
    run_all("pre_a");
    req = 6'b001100;
    push(6'b000000, 1, 1, 0, 1);
    push(6'b000000, 1, 0, 0, 1);
    push(6'b000100, 1, 0, 0, 12);
    run_all("pre_b");
    req = 6'b000000;
    push(6'b000000, 1, 0, 0, 2);
    push(6'b000000, 0, 0, 0, 2);
    run_all("pre_c");

    // Early release, then idle with no requests.
    do_reset(6'b000010);
    push(6'b000010, 1, 0, 0, 2);
    run_all("early_a");
    req = 6'b000000;
    push(6'b000000, 1, 0, 0, 2);
    push(6'b000000, 0, 0, 0, 4);
    run_all("early_b");

`ifdef HVAC_INTERLOCK_EN
    // Interlock: both requests blocked with conflict; changeover lockout.
    do_reset(6'b110000);
    push(6'b000000, 0, 0, 1, 5);
    run_all("hvac_conf");
    req = 6'b010000;
    push(6'b010000, 1, 0, 0, 8);
    run_all("hvac_heat");
    req = 6'b100000;
    push(6'b000000, 1, 0, 0, 2);
    push(6'b000000, 0, 0, 0, 15);
    push(6'b100000, 1, 0, 0, 2);
    run_all("hvac_lock");
`else
    // No interlock: heater and cooler alternate, conflict stays low.
    do_reset(6'b110000);
    push(6'b010000, 1, 0, 0, 8); push(6'b000000, 1, 0, 0, 2);
    push(6'b100000, 1, 0, 0, 8); push(6'b000000, 1, 0, 0, 2);
    push(6'b010000, 1, 0, 0, 2);
    run_all("hvac");
`endif

    // Reset mid-grant drops outputs immediately; regrant one edge after release.
    do_reset(6'b000010);
    push(6'b000010, 1, 0, 0, 3);
    run_all("mid_a");
    reset = 1'b0;
    #1;
    chk("mid.grant", {2'b00, grant}, 8'd0);
    chk("mid.code", {5'd0, code}, 8'd0);
    chk("mid.busy", {7'd0, busy}, 8'd0);
    chk("mid.preempted", {7'd0, preempted}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    push(6'b000010, 1, 0, 0, 2);
    run_all("mid_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
